axicb_mst_if: RTL

//  Per-master input stage of the crossbar, directly upstream of the master switch.

---
 rtl/axicb_pkg.sv | 19 +
 rtl/axicb_skid_buf.sv | 88 ++++++++
 rtl/axicb_mst_if.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/axicb_pkg.sv
// Shared definitions for the crossbar master-side input stage.
//   ID_LSB    : bit offset of the ID field inside every channel bundle (IDs sit in the LSBs)
//   cnt_width : width needed for an outstanding counter that must hold 0..max_val
//   skid_state_t : occupancy of a 2-entry skid buffer
package axicb_pkg;

    localparam int unsigned ID_LSB = 0;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } skid_state_t;

endpackage

// File: rtl/axicb_skid_buf.sv
// Two-entry skid buffer: one cycle latency, one beat per cycle, registered
// input ready. The output beat is held stable until it is accepted.
// Ports:
//   aclk, aresetn (async, active-low), srst (sync, active-high)
//   in_valid_i / in_ready_o / in_data_i    upstream side
//   out_valid_o / out_ready_i / out_data_o downstream side
module axicb_skid_buf
    import axicb_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
);

    skid_state_t       state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              ready_q;
    logic              push;
    logic              pop;

    assign in_ready_o  = ready_q;
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = head_q;

    assign push = in_valid_i & ready_q;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = in_data_i;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = in_data_i;
                end else if (push) begin
                    skid_d  = in_data_i;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // ready is low in FULL, so only a pop can happen here
                if (pop) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else if (srst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            ready_q <= (state_d != FULL);
        end
    end

endmodule

// File: rtl/axicb_mst_if.sv
// Per-master input stage of the crossbar, upstream of the master switch.
// AW/W/AR are registered through skid buffers; the master's ID mask is OR-ed
// into AW/AR IDs and cleared from returned B/R IDs (B/R path is combinational).
// With AXICB_MST_IF_OSTD_LIMIT_EN defined, outstanding writes/reads are counted,
// AW/AR are stalled at MST_OSTD_MAX, and ostd_err flags a response that arrives
// with nothing outstanding. Without it, ostd_err is tied low.
// Ports:
//   aclk, aresetn (async, active-low), srst (sync, active-high)
//   i_aw*/i_w*/i_ar* : master-side requests       o_aw*/o_w*/o_ar* : switch-side requests
//   i_b*/i_r*        : master-side responses      o_b*/o_r*        : switch-side responses
//   ostd_err         : sticky outstanding-underflow flag
module axicb_mst_if
    import axicb_pkg::*;
#(
    parameter int unsigned           AXI_ID_W     = 8,
    parameter int unsigned           AWCH_W       = 8,
    parameter int unsigned           WCH_W        = 8,
    parameter int unsigned           BCH_W        = 8,
    parameter int unsigned           ARCH_W       = 8,
    parameter int unsigned           RCH_W        = 8,
    parameter logic [AXI_ID_W-1:0]   MST_ID_MASK  = '0,
    parameter int unsigned           MST_OSTD_MAX = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    // master side
    input  logic              i_awvalid,
    output logic              i_awready,
    input  logic [AWCH_W-1:0] i_awch,
    input  logic              i_wvalid,
    output logic              i_wready,
    input  logic              i_wlast,
    input  logic [WCH_W-1:0]  i_wch,
    output logic              i_bvalid,
    input  logic              i_bready,
    output logic [BCH_W-1:0]  i_bch,
    input  logic              i_arvalid,
    output logic              i_arready,
    input  logic [ARCH_W-1:0] i_arch,
    output logic              i_rvalid,
    input  logic              i_rready,
    output logic              i_rlast,
    output logic [RCH_W-1:0]  i_rch,
    // switch side
    output logic              o_awvalid,
    input  logic              o_awready,
    output logic [AWCH_W-1:0] o_awch,
    output logic              o_wvalid,
    input  logic              o_wready,
    output logic              o_wlast,
    output logic [WCH_W-1:0]  o_wch,
    input  logic              o_bvalid,
    output logic              o_bready,
    input  logic [BCH_W-1:0]  o_bch,
    output logic              o_arvalid,
    input  logic              o_arready,
    output logic [ARCH_W-1:0] o_arch,
    input  logic              o_rvalid,
    output logic              o_rready,
    input  logic              o_rlast,
    input  logic [RCH_W-1:0]  o_rch,
    // status
    output logic              ostd_err
);

    if (MST_OSTD_MAX < 1 || MST_OSTD_MAX > 255) begin : g_bad_ostd_max
        $error("axicb_mst_if: MST_OSTD_MAX must be within 1..255");
    end

    // Mask widened to each bundle, placed on the ID field only
    localparam logic [AWCH_W-1:0] AW_ID_SET = AWCH_W'(MST_ID_MASK) << ID_LSB;
    localparam logic [ARCH_W-1:0] AR_ID_SET = ARCH_W'(MST_ID_MASK) << ID_LSB;
    localparam logic [BCH_W-1:0]  B_ID_CLR  = BCH_W'(MST_ID_MASK) << ID_LSB;
    localparam logic [RCH_W-1:0]  R_ID_CLR  = RCH_W'(MST_ID_MASK) << ID_LSB;

    logic              aw_buf_valid;
    logic              aw_buf_ready;
    logic [AWCH_W-1:0] aw_buf_data;
    logic              ar_buf_valid;
    logic              ar_buf_ready;
    logic [ARCH_W-1:0] ar_buf_data;
    logic [WCH_W:0]    w_buf_data;

    axicb_skid_buf #(.DATA_W(AWCH_W)) u_aw_buf (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .srst        (srst),
        .in_valid_i  (i_awvalid),
        .in_ready_o  (i_awready),
        .in_data_i   (i_awch),
        .out_valid_o (aw_buf_valid),
        .out_ready_i (aw_buf_ready),
        .out_data_o  (aw_buf_data)
    );

    axicb_skid_buf #(.DATA_W(WCH_W + 1)) u_w_buf (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .srst        (srst),
        .in_valid_i  (i_wvalid),
        .in_ready_o  (i_wready),
        .in_data_i   ({i_wlast, i_wch}),
        .out_valid_o (o_wvalid),
        .out_ready_i (o_wready),
        .out_data_o  (w_buf_data)
    );

    axicb_skid_buf #(.DATA_W(ARCH_W)) u_ar_buf (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .srst        (srst),
        .in_valid_i  (i_arvalid),
        .in_ready_o  (i_arready),
        .in_data_i   (i_arch),
        .out_valid_o (ar_buf_valid),
        .out_ready_i (ar_buf_ready),
        .out_data_o  (ar_buf_data)
    );

    assign o_wlast = w_buf_data[WCH_W];
    assign o_wch   = w_buf_data[WCH_W-1:0];

    // Remap is applied on the buffer output; equivalent to remapping on entry
    assign o_awch = aw_buf_data | AW_ID_SET;
    assign o_arch = ar_buf_data | AR_ID_SET;

    assign i_bvalid = o_bvalid;
    assign o_bready = i_bready;
    assign i_bch    = o_bch & ~B_ID_CLR;

    assign i_rvalid = o_rvalid;
    assign o_rready = i_rready;
    assign i_rlast  = o_rlast;
    assign i_rch    = o_rch & ~R_ID_CLR;

`ifdef AXICB_MST_IF_OSTD_LIMIT_EN
    localparam int unsigned    CNT_W   = cnt_width(MST_OSTD_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MST_OSTD_MAX);

    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             err_q, err_d;
    logic             wr_full, rd_full;
    logic             aw_hs, b_hs, ar_hs, r_hs;

    assign wr_full = (wr_cnt_q == CNT_MAX);
    assign rd_full = (rd_cnt_q == CNT_MAX);

    // At the limit the beat stays in the buffer and is hidden from the switch
    assign o_awvalid    = aw_buf_valid & ~wr_full;
    assign aw_buf_ready = o_awready & ~wr_full;
    assign o_arvalid    = ar_buf_valid & ~rd_full;
    assign ar_buf_ready = o_arready & ~rd_full;

    assign aw_hs = o_awvalid & o_awready;
    assign b_hs  = o_bvalid & i_bready;
    assign ar_hs = o_arvalid & o_arready;
    assign r_hs  = o_rvalid & i_rready & o_rlast;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        err_d    = err_q;

        if (b_hs && wr_cnt_q == '0) err_d = 1'b1;
        if (r_hs && rd_cnt_q == '0) err_d = 1'b1;

        if (aw_hs && !b_hs) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end else if (b_hs && !aw_hs && wr_cnt_q != '0) begin
            wr_cnt_d = wr_cnt_q - CNT_W'(1);
        end

        if (ar_hs && !r_hs) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end else if (r_hs && !ar_hs && rd_cnt_q != '0) begin
            rd_cnt_d = rd_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else if (srst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign ostd_err = err_q;
`else
    assign o_awvalid    = aw_buf_valid;
    assign aw_buf_ready = o_awready;
    assign o_arvalid    = ar_buf_valid;
    assign ar_buf_ready = o_arready;
    assign ostd_err     = 1'b0;
`endif

endmodule
